// File: rtl/snoop_bus_arbiter_if.sv
// Snooping coherence bus interface between the controller array and the
// bus arbiter.
//   master : the coherence controllers (drive req/req_msg/req_wb, observe
//            grant, done and the broadcast)
//   slave  : the arbiter (observes requests, drives grant/broadcast/done)
// Signals:
//   req       per-controller level request, held until done
//   req_msg   per-controller bus code, slice i = [3i+2:3i]
//   req_wb    per-controller writeback-before-broadcast flag
//   grant     one-hot bus ownership
//   wb_active writeback phase in progress
//   bus_valid one-cycle broadcast strobe; bus_msg/bus_src qualify it
//   done      one-cycle completion pulse to the winner
interface snoop_bus_arbiter_if #(
    parameter int N_CACHES = 4,
    parameter int SRC_W    = 2
);
    logic [N_CACHES-1:0]   req;
    logic [3*N_CACHES-1:0] req_msg;
    logic [N_CACHES-1:0]   req_wb;
    logic [N_CACHES-1:0]   grant;
    logic                  wb_active;
    logic                  bus_valid;
    logic [2:0]            bus_msg;
    logic [SRC_W-1:0]      bus_src;
    logic [N_CACHES-1:0]   done;

    modport master (
        output req, req_msg, req_wb,
        input  grant, wb_active, bus_valid, bus_msg, bus_src, done
    );

    modport slave (
        input  req, req_msg, req_wb,
        output grant, wb_active, bus_valid, bus_msg, bus_src, done
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Snooping bus arbiter: picks one pending coherence transaction, runs an
// optional writeback phase, broadcasts the bus code for one cycle and
// pulses done to the winner.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-low reset
//   bus    snoop_bus_arbiter_if.slave (requests in, grant/broadcast/done out)
// Build option:
//   ARB_FIXED_PRIORITY_EN  defined -> lowest eligible index always wins,
//                          pointer held at 0; undefined -> round-robin.
// Transaction timeline (edge 0 = arbitration edge):
//   SETUP (grant only) -> WB x WB_CYCLES (if req_wb) -> BCAST -> DONE -> IDLE
module snoop_bus_arbiter #(
    parameter int N_CACHES  = 4,
    parameter int WB_CYCLES = 2,
    parameter int SRC_W     = 2
) (
    input  logic               clock,
    input  logic               reset,
    snoop_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, WB, BCAST, DONE} state_t;

    localparam int CNT_W = $clog2(WB_CYCLES + 1);

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    win_q, win_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [2:0]          msg_q, msg_d;
    logic                wb_q, wb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [N_CACHES-1:0] grant_q, grant_d;
    logic                wb_active_q, wb_active_d;
    logic                bus_valid_q, bus_valid_d;
    logic [2:0]          bus_msg_q, bus_msg_d;
    logic [SRC_W-1:0]    bus_src_q, bus_src_d;
    logic [N_CACHES-1:0] done_q, done_d;

    logic [N_CACHES-1:0] elig;
    logic                sel_found;
    logic [SRC_W-1:0]    sel_idx;
    logic [2:0]          sel_msg;
    logic                sel_wb;
    logic                req_cur;
    logic [SRC_W-1:0]    ptr_after;

    function automatic logic [N_CACHES-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [N_CACHES-1:0] v;
        for (int i = 0; i < N_CACHES; i++) v[i] = (idx == SRC_W'(i));
        return v;
    endfunction

    // Only the three defined bus codes may win; 000 and 1xx wait forever.
    for (genvar i = 0; i < N_CACHES; i++) begin : g_elig
        assign elig[i] = bus.req[i] && !bus.req_msg[3*i+2] && (bus.req_msg[3*i +: 2] != 2'b00);
    end

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_CACHES; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(ptr_q) + k) % N_CACHES;
`endif
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel_idx   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        sel_msg = 3'b000;
        sel_wb  = 1'b0;
        for (int i = 0; i < N_CACHES; i++) begin
            if (sel_idx == SRC_W'(i)) begin
                sel_msg = bus.req_msg[3*i +: 3];
                sel_wb  = bus.req_wb[i];
            end
        end
    end

    assign req_cur = |(bus.req & onehot(win_q));

`ifdef ARB_FIXED_PRIORITY_EN
    assign ptr_after = '0;
`else
    assign ptr_after = (win_q == SRC_W'(N_CACHES - 1)) ? '0 : win_q + SRC_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        msg_d   = msg_q;
        wb_d    = wb_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (sel_found) begin
                win_d   = sel_idx;
                msg_d   = sel_msg;
                wb_d    = sel_wb;
                state_d = SETUP;
            end
            SETUP: begin
                state_d = wb_q ? WB : BCAST;
                cnt_d   = CNT_W'(1);
            end
            WB: begin
                if (!req_cur) begin
                    state_d = IDLE;
                    ptr_d   = ptr_after;
                end else if (cnt_q == CNT_W'(WB_CYCLES)) begin
                    state_d = BCAST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BCAST: begin
                ptr_d   = req_cur ? ptr_q : ptr_after;
                state_d = req_cur ? DONE : IDLE;
            end
            DONE: begin
                // A request drop here is ignored: the transaction is complete.
                state_d = IDLE;
                ptr_d   = ptr_after;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are the registered decode of the state being entered.
        grant_d     = '0;
        bus_src_d   = '0;
        if (state_d != IDLE) begin
            grant_d   = onehot(win_d);
            bus_src_d = win_d;
        end
        wb_active_d = (state_d == WB);
        bus_valid_d = (state_d == BCAST);
        bus_msg_d   = bus_valid_d ? msg_d : 3'b000;
        done_d      = (state_d == DONE) ? onehot(win_d) : '0;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            win_q       <= '0;
            ptr_q       <= '0;
            msg_q       <= 3'b000;
            wb_q        <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= '0;
            wb_active_q <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_msg_q   <= 3'b000;
            bus_src_q   <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            ptr_q       <= ptr_d;
            msg_q       <= msg_d;
            wb_q        <= wb_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            wb_active_q <= wb_active_d;
            bus_valid_q <= bus_valid_d;
            bus_msg_q   <= bus_msg_d;
            bus_src_q   <= bus_src_d;
            done_q      <= done_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.wb_active = wb_active_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_msg   = bus_msg_q;
    assign bus.bus_src   = bus_src_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: table-driven single
// transactions, hand-written multi-cycle sequences, then randomized
// controller traffic checked every cycle against a transaction-level model.
module tb_snoop_bus_arbiter;
    localparam int N  = 4;
    localparam int WB = 2;
    localparam int SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    snoop_bus_arbiter_if #(.N_CACHES(N), .SRC_W(SW)) bif();

    snoop_bus_arbiter #(.N_CACHES(N), .WB_CYCLES(WB), .SRC_W(SW)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: m_t counts cycles since the grant edge.
    // Cycle 1 grant only, 2..WB+1 writeback (if any), then broadcast, then done.
    bit         m_busy = 1'b0;
    int         m_win = 0, m_t = 0, m_ptr = 0;
    logic [2:0] m_msg = 3'b000;
    bit         m_wb = 1'b0;

    function automatic int m_len();
        return m_wb ? WB + 3 : 3;
    endfunction

    function automatic bit eligible(int i);
        logic [2:0] c;
        c = bif.req_msg[3*i +: 3];
        return bif.req[i] && c >= 3'd1 && c <= 3'd3;
    endfunction

    function automatic int after(int w);
`ifdef ARB_FIXED_PRIORITY_EN
        return 0 * w;
`else
        return (w + 1) % N;
`endif
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_busy = 1'b0; m_ptr = 0; m_win = 0; m_t = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int i;
`ifdef ARB_FIXED_PRIORITY_EN
                i = k;
`else
                i = (m_ptr + k) % N;
`endif
                if (!m_busy && eligible(i)) begin
                    m_busy = 1'b1; m_win = i; m_t = 1;
                    m_msg = bif.req_msg[3*i +: 3]; m_wb = bif.req_wb[i];
                end
            end
        end else if (m_t == m_len() || (m_t >= 2 && !bif.req[m_win])) begin
            m_busy = 1'b0; m_ptr = after(m_win);
        end else begin
            m_t++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic compare();
        logic [N-1:0] g, d;
        bit wa, bv;
        logic [2:0] bm;
        int src;
        g = '0; d = '0; wa = 0; bv = 0; bm = 3'b000; src = 0;
        if (m_busy) begin
            g[m_win] = 1'b1;
            src = m_win;
            wa = m_wb && m_t >= 2 && m_t <= WB + 1;
            bv = (m_t == m_len() - 1);
            if (bv) bm = m_msg;
            if (m_t == m_len()) d[m_win] = 1'b1;
        end
        chk("grant", 32'(bif.grant), 32'(g));
        chk("wb_active", 32'(bif.wb_active), 32'(wa));
        chk("bus_valid", 32'(bif.bus_valid), 32'(bv));
        chk("bus_msg", 32'(bif.bus_msg), 32'(bm));
        chk("bus_src", 32'(bif.bus_src), 32'(src));
        chk("done", 32'(bif.done), 32'(d));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        bif.req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(output int who);
        who = -1;
        for (int c = 0; c < 20 && who < 0; c++) begin
            step();
            for (int i = 0; i < N; i++) if (bif.done[i]) who = i;
        end
    endtask

    function automatic logic [2:0] pick_msg();
        if ($urandom_range(0, 9) < 8) return 3'($urandom_range(1, 3));
        return ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(4, 7));
    endfunction

    typedef struct {
        logic [N-1:0]   req;
        logic [3*N-1:0] msg;
        logic [N-1:0]   wb;
        int             src;
        logic [2:0]     bmsg;
        int             bv_k;
        int             done_k;
        int             wb_cyc;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int who;
        bif.req = '0; bif.req_msg = '0; bif.req_wb = '0;

        vecs[0] = '{4'b0001, 12'h001, 4'b0000, 0, 3'b001, 1, 2, 0};
        vecs[1] = '{4'b0100, 12'h080, 4'b0100, 2, 3'b010, WB + 1, WB + 2, WB};
        vecs[2] = '{4'b1010, 12'h218, 4'b0000, 1, 3'b011, 1, 2, 0};
        vecs[3] = '{4'b1001, 12'h404, 4'b1000, 3, 3'b010, WB + 1, WB + 2, WB};
        vecs[4] = '{4'b0110, 12'h040, 4'b0000, 2, 3'b001, 1, 2, 0};

        do_reset();
        chk("reset_grant", 32'(bif.grant), 32'd0);
        chk("reset_bus_src", 32'(bif.bus_src), 32'd0);

        // Single transactions from a reset pointer.
        for (int v = 0; v < 5; v++) begin
            int src, bv_k, done_k, wbc;
            logic [2:0] bmsg;
            do_reset();
            bif.req = vecs[v].req; bif.req_msg = vecs[v].msg; bif.req_wb = vecs[v].wb;
            src = -1; bv_k = -1; done_k = -1; wbc = 0; bmsg = 3'b000;
            for (int k = 0; k < 12 && done_k < 0; k++) begin
                step();
                if (k == 0) src = int'(bif.bus_src);
                if (bif.wb_active) wbc++;
                if (bif.bus_valid && bv_k < 0) begin bv_k = k; bmsg = bif.bus_msg; end
                if (bif.done != '0) done_k = k;
            end
            bif.req = '0;
            chk("vec_src", 32'(src), 32'(vecs[v].src));
            chk("vec_bus_msg", 32'(bmsg), 32'(vecs[v].bmsg));
            chk("vec_bv_latency", 32'(bv_k), 32'(vecs[v].bv_k));
            chk("vec_done_latency", 32'(done_k), 32'(vecs[v].done_k));
            chk("vec_wb_cycles", 32'(wbc), 32'(vecs[v].wb_cyc));
        end

        // All four requesting at once.
        do_reset();
        bif.req = 4'b1111; bif.req_msg = 12'h6DB; bif.req_wb = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int e = 0; e < 3; e++) begin
            wait_done(who);
            chk("fixed_order", 32'(who), 32'd0);
        end
`else
        for (int e = 0; e < 4; e++) begin
            wait_done(who);
            chk("rr_order", 32'(who), 32'(e));
            if (who >= 0 && who < 3) bif.req[who] = 1'b0;
        end
        bif.req[0] = 1'b1;   // req3 still pending, pointer wrapped to 0
        wait_done(who);
        chk("rr_wrap", 32'(who), 32'd0);
`endif
        bif.req = '0;
        step(); step();

        // Invalid codes are never granted.
        bif.req = 4'b0110; bif.req_msg = 12'h100;   // msg1=000, msg2=100
        for (int c = 0; c < 6; c++) begin
            step();
            chk("invalid_no_grant", 32'(bif.grant), 32'd0);
        end
        bif.req = '0;

        // Abort during the second writeback cycle.
        do_reset();
        bif.req = 4'b0110; bif.req_msg = 12'h088; bif.req_wb = 4'b0010;
        step(); chk("abort_grant", 32'(bif.grant), 32'b0010);
        step(); chk("abort_wb1", 32'(bif.wb_active), 32'd1);
        step(); chk("abort_wb2", 32'(bif.wb_active), 32'd1);
        bif.req[1] = 1'b0;
        step();
        chk("abort_grant_clr", 32'(bif.grant), 32'd0);
        chk("abort_no_bv", 32'(bif.bus_valid), 32'd0);
        chk("abort_no_done", 32'(bif.done), 32'd0);
        step(); chk("abort_next", 32'(bif.grant), 32'b0100);
        wait_done(who);
        chk("abort_next_done", 32'(who), 32'd2);
        bif.req = '0; bif.req_wb = '0;
        step(); step();

        // Reset during broadcast, pointer left non-zero by the last transaction.
        bif.req = 4'b0001; bif.req_msg = 12'h001;
        step(); chk("rstb_grant", 32'(bif.grant), 32'b0001);
        step(); chk("rstb_bv", 32'(bif.bus_valid), 32'd1);
        rst_n = 1'b0;
        bif.req = 4'b1010; bif.req_msg = 12'h208;
        step();
        chk("rstb_grant0", 32'(bif.grant), 32'd0);
        chk("rstb_bv0", 32'(bif.bus_valid), 32'd0);
        chk("rstb_done0", 32'(bif.done), 32'd0);
        rst_n = 1'b1;
        step(); chk("rstb_ptr0", 32'(bif.grant), 32'b0010);
        wait_done(who);
        chk("rstb_done", 32'(who), 32'd1);
        bif.req = '0;
        step(); step();

        // Randomized controller traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                bit dn;
                dn = m_busy && m_win == i && m_t == m_len();
                if (!bif.req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        bif.req[i] = 1'b1;
                        bif.req_msg[3*i +: 3] = pick_msg();
                        bif.req_wb[i] = 1'($urandom_range(0, 1));
                    end
                end else if (dn) begin
                    if ($urandom_range(0, 3) != 0) bif.req[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    bif.req[i] = 1'b0;
                end
                // The winner's live code must not leak into the broadcast.
                if (m_busy && m_win == i) bif.req_msg[3*i +: 3] = 3'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
